// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Package  : eth_pkg
// Brief    : Ethernet/ARP field constants and transmit FSM state encoding.
// Revision : 1.0
// ============================================================================
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [7:0]  ARP_HLEN_ETH   = 8'h06;
    localparam logic [7:0]  ARP_PLEN_IPV4  = 8'h04;
    localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
    localparam logic [15:0] ARP_OPER_RESP  = 16'h0002;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam int          PREAMBLE_LEN   = 7;
    localparam int          IFG_LEN        = 12;
    localparam int          MIN_PAD_LEN    = 18;

    // Byte offsets within the frame, counted from the first preamble byte
    localparam logic [6:0]  OFS_SFD        = 7'd7;
    localparam logic [6:0]  OFS_HDR_LAST   = 7'd49;
    localparam logic [6:0]  OFS_PAD_LAST   = 7'd67;
    localparam logic [6:0]  OFS_FCS_LAST   = 7'd71;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_HEADER   = 3'd2,
        ST_PAD      = 3'd3,
        ST_FCS      = 3'd4,
        ST_IFG      = 3'd5
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/eth_crc32.sv
`default_nettype none
// ============================================================================
// Module   : eth_crc32
// Brief    : Byte-wise Ethernet CRC-32 (poly 0x04C11DB7, reflected, init all-ones).
//            crc is the raw register; the caller complements it for the FCS.
// Revision : 1.0
// ============================================================================
module eth_crc32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    localparam logic [31:0] c_poly_refl = 32'hEDB8_8320;

    logic [31:0] r_crc;
    logic [31:0] w_crc_next;

    // LSB-first shift of one byte through the reflected polynomial
    always_comb begin
        w_crc_next = r_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_crc_next[0] ^ data[i]) begin
                w_crc_next = (w_crc_next >> 1) ^ c_poly_refl;
            end else begin
                w_crc_next = w_crc_next >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= '1;
        end else if (init) begin
            r_crc <= '1;
        end else if (en) begin
            r_crc <= w_crc_next;
        end
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/arp_reply_tx.sv
`default_nettype none
// ============================================================================
// Module   : arp_reply_tx
// Brief    : Builds and streams ARP reply frames (preamble to pad/FCS) for
//            decoded ARP requests addressed to SELF_IP, with one pending slot.
// Config   : define ARP_REPLY_FCS_EN to append the CRC-32 FCS (72-byte frame);
//            otherwise the frame ends after the pad (68 bytes).
// Revision : 1.0
// ============================================================================
module arp_reply_tx
    import eth_pkg::*;
#(
    parameter logic [47:0] SELF_MAC = 48'h0023_543C_471B,
    parameter logic [31:0] SELF_IP  = 32'h0A00_0021
) (
    input  logic        eth_tx_clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [47:0] i_req_sha,
    input  logic [31:0] i_req_spa,
    input  logic [31:0] i_req_tpa,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_en,
    output logic        o_busy,
    output logic [15:0] o_reply_cnt,
    output logic [15:0] o_drop_cnt
);

    localparam logic [3:0] c_ifg_last = 4'(IFG_LEN - 1);

    tx_state_t r_state;
    tx_state_t w_next_state;

    logic [6:0]  r_byte_idx;
    logic [3:0]  r_ifg_cnt;
    logic        r_slot_full;
    logic [47:0] r_slot_sha;
    logic [31:0] r_slot_spa;
    logic [47:0] r_act_sha;
    logic [31:0] r_act_spa;
    logic [15:0] r_reply_cnt;
    logic [15:0] r_drop_cnt;

    logic        w_accept;
    logic        w_tpa_hit;
    logic        w_load;
    logic        w_last_byte;
    logic        w_in_frame;
    logic [7:0]  w_tx_data;
    logic [5:0]  w_hdr_sel;
    logic [41:0][7:0] w_hdr_bytes;

    assign w_accept  = i_req_valid & ~r_slot_full;
    assign w_tpa_hit = (i_req_tpa == SELF_IP);
    assign w_in_frame = (r_state == ST_PREAMBLE) || (r_state == ST_HEADER) ||
                        (r_state == ST_PAD)      || (r_state == ST_FCS);

    // Offsets 8..49 in transmit order; entry 41 is the first header byte
    assign w_hdr_bytes = {r_act_sha, SELF_MAC, ETHERTYPE_ARP, ARP_HTYPE_ETH,
                          ETHERTYPE_IPV4, ARP_HLEN_ETH, ARP_PLEN_IPV4,
                          ARP_OPER_RESP, SELF_MAC, SELF_IP, r_act_sha, r_act_spa};
    assign w_hdr_sel   = 6'(OFS_HDR_LAST - r_byte_idx);

`ifdef ARP_REPLY_FCS_EN
    logic [31:0]     w_crc;
    logic [3:0][7:0] w_fcs_bytes;
    logic            w_crc_en;

    assign w_crc_en    = (r_state == ST_HEADER) || (r_state == ST_PAD);
    assign w_fcs_bytes = ~w_crc;

    eth_crc32 u_crc (
        .clk   (eth_tx_clk),
        .rst_n (rst_n),
        .init  (w_load),
        .en    (w_crc_en),
        .data  (w_tx_data),
        .crc   (w_crc)
    );
`endif

    always_ff @(posedge eth_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_last_byte  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_slot_full) begin
                    w_next_state = ST_PREAMBLE;
                    w_load       = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                if (r_byte_idx == OFS_SFD) w_next_state = ST_HEADER;
            end
            ST_HEADER: begin
                if (r_byte_idx == OFS_HDR_LAST) w_next_state = ST_PAD;
            end
            ST_PAD: begin
                if (r_byte_idx == OFS_PAD_LAST) begin
`ifdef ARP_REPLY_FCS_EN
                    w_next_state = ST_FCS;
`else
                    w_next_state = ST_IFG;
                    w_last_byte  = 1'b1;
`endif
                end
            end
`ifdef ARP_REPLY_FCS_EN
            ST_FCS: begin
                if (r_byte_idx == OFS_FCS_LAST) begin
                    w_next_state = ST_IFG;
                    w_last_byte  = 1'b1;
                end
            end
`endif
            ST_IFG: begin
                // A waiting request starts right after the gap, skipping IDLE
                if (r_ifg_cnt == c_ifg_last) begin
                    if (r_slot_full) begin
                        w_next_state = ST_PREAMBLE;
                        w_load       = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tx_data = 8'h00;
        case (r_state)
            ST_PREAMBLE: w_tx_data = (r_byte_idx == OFS_SFD) ? SFD_BYTE : PREAMBLE_BYTE;
            ST_HEADER:   w_tx_data = w_hdr_bytes[w_hdr_sel];
`ifdef ARP_REPLY_FCS_EN
            ST_FCS:      w_tx_data = w_fcs_bytes[r_byte_idx[1:0]];
`endif
            default:     w_tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge eth_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_idx <= '0;
            r_ifg_cnt  <= '0;
        end else begin
            if (w_load) begin
                r_byte_idx <= '0;
            end else if (w_in_frame) begin
                r_byte_idx <= r_byte_idx + 7'd1;
            end
            if (r_state == ST_IFG) begin
                r_ifg_cnt <= r_ifg_cnt + 4'd1;
            end else begin
                r_ifg_cnt <= '0;
            end
        end
    end

    // Load and accept never coincide: load needs a full slot, accept an empty one
    always_ff @(posedge eth_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_full <= 1'b0;
            r_slot_sha  <= '0;
            r_slot_spa  <= '0;
            r_act_sha   <= '0;
            r_act_spa   <= '0;
            r_drop_cnt  <= '0;
            r_reply_cnt <= '0;
        end else begin
            if (w_load) begin
                r_slot_full <= 1'b0;
                r_act_sha   <= r_slot_sha;
                r_act_spa   <= r_slot_spa;
            end else if (w_accept && w_tpa_hit) begin
                r_slot_full <= 1'b1;
                r_slot_sha  <= i_req_sha;
                r_slot_spa  <= i_req_spa;
            end
            if (w_accept && !w_tpa_hit) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_last_byte) begin
                r_reply_cnt <= r_reply_cnt + 16'd1;
            end
        end
    end

    assign o_req_ready = ~r_slot_full;
    assign o_tx_en     = w_in_frame;
    assign o_tx_data   = w_tx_data;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_reply_cnt = r_reply_cnt;
    assign o_drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_arp_reply_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_arp_reply_tx
// Brief    : Scoreboard bench for arp_reply_tx; expected frame bytes are queued
//            at request acceptance and popped by a negedge monitor.
// Revision : 1.0
// ============================================================================
module tb_arp_reply_tx;

    localparam logic [47:0] SELF_MAC = 48'h0023_543C_471B;
    localparam logic [31:0] SELF_IP  = 32'h0A00_0021;
`ifdef ARP_REPLY_FCS_EN
    localparam int FRAME_LEN = 72;
`else
    localparam int FRAME_LEN = 68;
`endif

    logic        eth_tx_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [47:0] i_req_sha = '0;
    logic [31:0] i_req_spa = '0;
    logic [31:0] i_req_tpa = '0;
    logic [7:0]  o_tx_data;
    logic        o_tx_en;
    logic        o_busy;
    logic [15:0] o_reply_cnt;
    logic [15:0] o_drop_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int frame_start[$];
    int frame_end[$];
    logic [7:0] rx[72];
    int  cur_len = 0;
    bit  in_frame = 1'b0;

    arp_reply_tx dut (
        .eth_tx_clk  (eth_tx_clk),
        .rst_n       (rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_sha   (i_req_sha),
        .i_req_spa   (i_req_spa),
        .i_req_tpa   (i_req_tpa),
        .o_tx_data   (o_tx_data),
        .o_tx_en     (o_tx_en),
        .o_busy      (o_busy),
        .o_reply_cnt (o_reply_cnt),
        .o_drop_cnt  (o_drop_cnt)
    );

    always #5 eth_tx_clk = ~eth_tx_clk;
    always @(posedge eth_tx_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

`ifdef ARP_REPLY_FCS_EN
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction
`endif

    task automatic push_frame(input logic [47:0] sha, input logic [31:0] spa);
        logic [7:0]  f[72];
        logic [31:0] c;
        for (int i = 0; i < 72; i++) f[i] = 8'h00;
        for (int i = 0; i < 7; i++) f[i] = 8'h55;
        f[7] = 8'hD5;
        for (int i = 0; i < 6; i++) begin
            f[8 + i]  = sha[47 - 8*i -: 8];
            f[14 + i] = SELF_MAC[47 - 8*i -: 8];
            f[30 + i] = SELF_MAC[47 - 8*i -: 8];
            f[40 + i] = sha[47 - 8*i -: 8];
        end
        f[20] = 8'h08; f[21] = 8'h06; f[22] = 8'h00; f[23] = 8'h01;
        f[24] = 8'h08; f[25] = 8'h00; f[26] = 8'h06; f[27] = 8'h04;
        f[28] = 8'h00; f[29] = 8'h02;
        for (int i = 0; i < 4; i++) begin
            f[36 + i] = SELF_IP[31 - 8*i -: 8];
            f[46 + i] = spa[31 - 8*i -: 8];
        end
        c = 32'hFFFF_FFFF;
`ifdef ARP_REPLY_FCS_EN
        for (int i = 8; i < 68; i++) c = crc_upd(c, f[i]);
        c = ~c;
        f[68] = c[7:0]; f[69] = c[15:8]; f[70] = c[23:16]; f[71] = c[31:24];
`endif
        for (int i = 0; i < FRAME_LEN; i++) exp_q.push_back(f[i]);
    endtask

    // Monitor: compare each transmitted byte against the scoreboard queue
    always @(negedge eth_tx_clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            cur_len  = 0;
        end else if (o_tx_en) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                cur_len  = 0;
                frame_start.push_back(cyc);
            end
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 64'(o_tx_en), 64'(0));
            end else begin
                check($sformatf("byte%0d", cur_len), 64'(o_tx_data), 64'(exp_q.pop_front()));
            end
            if (cur_len < 72) rx[cur_len] = o_tx_data;
            cur_len++;
        end else begin
            check("idle_data", 64'(o_tx_data), 64'(0));
            if (in_frame) begin
                in_frame = 1'b0;
                frame_end.push_back(cyc - 1);
                check("frame_len", 64'(cur_len), 64'(FRAME_LEN));
`ifdef ARP_REPLY_FCS_EN
                begin
                    logic [31:0] c;
                    c = 32'hFFFF_FFFF;
                    for (int i = 8; i < 72; i++) c = crc_upd(c, rx[i]);
                    check("fcs_residue", 64'(c), 64'(32'hDEBB_20E3));
                end
`endif
            end
        end
    end

    task automatic send_req(input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
        bit   acc;
        logic rdy;
        acc = 1'b0;
        i_req_valid = 1'b1;
        i_req_sha   = sha;
        i_req_spa   = spa;
        i_req_tpa   = tpa;
        for (int k = 0; k < 2000 && !acc; k++) begin
            @(negedge eth_tx_clk);
            rdy = o_req_ready;
            @(posedge eth_tx_clk);
            #1;
            acc = rdy;
        end
        i_req_valid = 1'b0;
        if (!acc) check("req_accept_timeout", 64'(acc), 64'(1));
        else if (tpa == SELF_IP) push_frame(sha, spa);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(posedge eth_tx_clk);
            #1;
            done = !o_busy && (exp_q.size() == 0);
        end
        if (!done) check("idle_timeout", 64'(done), 64'(1));
    endtask

    task automatic wait_tx_en();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(posedge eth_tx_clk);
            #1;
            seen = o_tx_en;
        end
        if (!seen) check("tx_en_timeout", 64'(seen), 64'(1));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(posedge eth_tx_clk);
        #1;
        check("rst_tx_en", 64'(o_tx_en), 64'(0));
        check("rst_tx_data", 64'(o_tx_data), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_ready", 64'(o_req_ready), 64'(1));
        check("rst_reply_cnt", 64'(o_reply_cnt), 64'(0));
        check("rst_drop_cnt", 64'(o_drop_cnt), 64'(0));
        @(negedge eth_tx_clk);
        rst_n = 1'b1;
        repeat (2) @(posedge eth_tx_clk);
        #1;

        // Basic reply and first-byte latency
        send_req(48'h0011_2233_4455, 32'h0A00_0002, SELF_IP);
        check("lat_n1_tx_en", 64'(o_tx_en), 64'(0));
        @(posedge eth_tx_clk);
        #1;
        check("lat_n2_tx_en", 64'(o_tx_en), 64'(1));
        check("lat_n2_data", 64'(o_tx_data), 64'(8'h55));
        check("lat_n2_busy", 64'(o_busy), 64'(1));
        wait_idle();
        check("reply_cnt_1", 64'(o_reply_cnt), 64'(1));
        check("a_byte8", 64'(rx[8]), 64'(8'h00));
        check("a_byte13", 64'(rx[13]), 64'(8'h55));
        check("a_ethertype", 64'({rx[20], rx[21]}), 64'(16'h0806));
        check("a_oper", 64'({rx[28], rx[29]}), 64'(16'h0002));
        check("a_tpa", 64'({rx[46], rx[47], rx[48], rx[49]}), 64'(32'h0A00_0002));

        // Request for another IP is dropped
        send_req(48'hAABB_CCDD_EEFF, 32'h0A00_0005, 32'h0A00_0063);
        check("drop_cnt_1", 64'(o_drop_cnt), 64'(1));
        check("drop_ready", 64'(o_req_ready), 64'(1));
        repeat (10) @(posedge eth_tx_clk);
        #1;
        check("drop_busy", 64'(o_busy), 64'(0));
        check("drop_ready_later", 64'(o_req_ready), 64'(1));
        check("drop_reply_cnt", 64'(o_reply_cnt), 64'(1));

        // Back-to-back frames and full-slot backpressure
        send_req(48'h0200_0000_0001, 32'h0A00_0010, SELF_IP);
        wait_tx_en();
        repeat (5) @(posedge eth_tx_clk);
        #1;
        send_req(48'h0200_0000_0002, 32'hC0A8_0107, SELF_IP);
        i_req_valid = 1'b1;
        i_req_sha   = 48'h0200_0000_0003;
        i_req_spa   = 32'h0A00_0011;
        i_req_tpa   = SELF_IP;
        @(negedge eth_tx_clk);
        check("full_slot_ready", 64'(o_req_ready), 64'(0));
        @(posedge eth_tx_clk);
        #1;
        i_req_valid = 1'b0;
        wait_idle();
        check("reply_cnt_3", 64'(o_reply_cnt), 64'(3));
        check("drop_cnt_still_1", 64'(o_drop_cnt), 64'(1));
        n = frame_start.size();
        if (n >= 2 && frame_end.size() >= 2) begin
            check("ifg_gap", 64'(frame_start[n-1] - frame_end[n-2] - 1), 64'(12));
        end else begin
            check("frame_count", 64'(n), 64'(3));
        end

        // Reset in the middle of a frame
        send_req(48'h0200_0000_0004, 32'h0A00_0012, SELF_IP);
        wait_tx_en();
        repeat (30) @(posedge eth_tx_clk);
        #1;
        check("pre_rst_tx_en", 64'(o_tx_en), 64'(1));
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_tx_en", 64'(o_tx_en), 64'(0));
        check("async_rst_data", 64'(o_tx_data), 64'(0));
        check("async_rst_busy", 64'(o_busy), 64'(0));
        check("async_rst_ready", 64'(o_req_ready), 64'(1));
        check("async_rst_reply", 64'(o_reply_cnt), 64'(0));
        repeat (3) @(posedge eth_tx_clk);
        @(negedge eth_tx_clk);
        rst_n = 1'b1;
        repeat (40) @(posedge eth_tx_clk);
        #1;
        check("post_rst_busy", 64'(o_busy), 64'(0));
        check("post_rst_tx_en", 64'(o_tx_en), 64'(0));

        // Reply counter wrap
        force dut.r_reply_cnt = 16'hFFFF;
        @(posedge eth_tx_clk);
        #1;
        release dut.r_reply_cnt;
        @(posedge eth_tx_clk);
        #1;
        check("preload_reply", 64'(o_reply_cnt), 64'(16'hFFFF));
        send_req(48'h0200_0000_0005, 32'h0A00_0013, SELF_IP);
        wait_idle();
        check("reply_wrap", 64'(o_reply_cnt), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
